player_input_filter: RTL and testbench
======================================

Name: player_input_filter

Overview:
- Sits directly downstream of the vision quadrant stage, in the pixel clock domain.
- Consumes the 9-bit per-frame quadrant occupancy map and its frame-valid level.
- Turns noisy per-frame maps into a debounced lane (0 left, 1 centre, 2 right), a single-cycle jump pulse and a player-present flag for the game logic.
- Temporal filtering uses per-frame counters and a jump state machine.

Parameters:
- LANE_STABLE_FRAMES, 3: consecutive frames with the same lane candidate needed before lane changes (1..15).
- JUMP_FRAMES, 2: consecutive airborne frames needed to fire jump (1..15).
- REARM_FRAMES, 2: consecutive grounded frames needed before another jump can fire (1..15).
- LOST_FRAMES, 8: consecutive empty frames before player_present drops (1..15).

Ports:
- pixel_clock_in  in  1  system clock.
- rst_in  in  1  synchronous, active-high reset.
- quadrants_in  in  9  occupancy map; bit index = row*3+col, row 0 is top.
- quadrants_valid_in  in  1  level signal; may stay high for many cycles per frame.
- lane  out  2  debounced lane (0/1/2; 3 never driven).
- jump  out  1  one-cycle pulse per detected jump.
- player_present  out  1  high while a player blob is being tracked.
- out_valid  out  1  one-cycle pulse when a frame has been processed.

Behaviour:
- Clock and reset:
  - One clock, pixel_clock_in; rst_in is synchronous, active-high.
  - Reset values: lane=1, jump=0, player_present=0, out_valid=0, all counters 0, jump FSM=GROUNDED, valid-edge register 0.
  - Reset mid-frame discards any partially processed frame.
- Frame capture:
  - A frame event is a rising edge of quadrants_valid_in (high now, low on the previous cycle).
  - If the edge is sampled at cycle N, quadrants_in is latched at N.
  - Outputs update and out_valid pulses at N+2.
  - Holding quadrants_valid_in high produces no further events.
  - A high level coming out of reset counts as an edge, because the edge register resets to 0.
- Derived per-frame terms:
  - top = q0|q1|q2; bottom = q6|q7|q8; empty = (q==0).
  - airborne = top & !bottom; grounded = bottom.
  - Lane candidate comes from the middle row only: exactly one of q3/q4/q5 set gives column 0/1/2 respectively. Otherwise there is no candidate.
- Lane debounce:
  - The candidate register and stable counter (4 bits, saturating at 15) track the candidate.
  - Same candidate as the previous frame: counter increments.
  - Different candidate: candidate register is loaded and the counter is set to 1.
  - No candidate: counter is cleared and the candidate register holds.
  - lane is loaded with the candidate when counter >= LANE_STABLE_FRAMES. Non-adjacent moves (0->2) are permitted.
- Presence:
  - Lost counter (4 bits, saturating): an empty frame increments it; any non-empty frame clears it and sets player_present=1.
  - player_present clears when the lost counter reaches LOST_FRAMES.
  - lane holds its value while the player is absent.
- Jump FSM, one transition per frame event:
  - GROUNDED: airborne frame -> RISING with the counter set to 1. If JUMP_FRAMES==1, fire immediately -> AIRBORNE.
  - RISING:
    - Airborne frame increments the counter.
    - When the counter reaches JUMP_FRAMES: jump=1 for the out_valid cycle, counter cleared, go to AIRBORNE.
    - Any non-airborne frame -> GROUNDED, counter cleared.
  - AIRBORNE:
    - Grounded frame increments the rearm counter.
    - Any non-grounded frame (including empty) clears the rearm counter.
    - When the rearm counter reaches REARM_FRAMES -> GROUNDED.
- Output timing:
  - jump and out_valid are single-cycle pulses, coincident.
  - Lane change and jump may occur in the same frame.
  - All outputs are registered; there are no combinational paths from inputs.

Test Plan:
- Reset, then 3 frames of 9'b000_010_000 (q4, with q7 for ground: 9'b010_010_000) -> lane stays 1, player_present=1 after frame 1, out_valid exactly 2 cycles after each valid edge.
- Frames with q3|q6 set, sequence L,L,R,L,L,L (R = q5|q8) -> lane stays 1 until the 3rd consecutive L after R, then lane=0. Holding valid high for 500 cycles yields one out_valid.
- Frames q4|q7, then q1|q4 (airborne) x2 -> one jump pulse on the 2nd airborne frame. A 3rd airborne frame gives no pulse. Two q4|q7 frames, then two airborne frames -> second jump.
- Airborne, grounded, airborne, grounded (alternating) -> no jump ever. FSM bounces between RISING and GROUNDED.
- 7 empty frames -> player_present=1. 8th empty -> player_present=0, lane unchanged. Next non-empty frame -> player_present=1.
- Assert rst_in one cycle after a valid edge with an airborne frame mid-RISING -> no out_valid, lane=1, jump=0. The next two airborne frames fire jump on the second.

Source files
------------

// File: rtl/player_input_filter.sv
// rtl/player_input_filter.sv - debounces per-frame quadrant maps into lane, jump and presence
//
// Ports:
//   pixel_clock_in      clock
//   rst_in              synchronous active-high reset
//   quadrants_in        9-bit occupancy map, bit = row*3+col, row 0 on top
//   quadrants_valid_in  frame-valid level; each rising edge is one frame event
//   lane                debounced lane 0/1/2 (left/centre/right)
//   jump                one-cycle pulse, coincident with out_valid
//   player_present      high while a player blob is tracked
//   out_valid           one-cycle pulse two cycles after the frame edge
module player_input_filter #(
    parameter int unsigned LANE_STABLE_FRAMES = 3,
    parameter int unsigned JUMP_FRAMES        = 2,
    parameter int unsigned REARM_FRAMES       = 2,
    parameter int unsigned LOST_FRAMES        = 8
) (
    input  logic       pixel_clock_in,
    input  logic       rst_in,
    input  logic [8:0] quadrants_in,
    input  logic       quadrants_valid_in,
    output logic [1:0] lane,
    output logic       jump,
    output logic       player_present,
    output logic       out_valid
);

    localparam logic [3:0] LANE_N  = 4'(LANE_STABLE_FRAMES);
    localparam logic [3:0] JUMP_N  = 4'(JUMP_FRAMES);
    localparam logic [3:0] REARM_N = 4'(REARM_FRAMES);
    localparam logic [3:0] LOST_N  = 4'(LOST_FRAMES);

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        AIRBORNE = 2'd2
    } jump_state_e;

    // Stage 1: edge detect and map capture
    logic       valid_prev_q;
    logic       ev1_q;
    logic [8:0] quad_q;
    logic       frame_edge;

    assign frame_edge = quadrants_valid_in & ~valid_prev_q;

    always_ff @(posedge pixel_clock_in) begin
        if (rst_in) begin
            valid_prev_q <= 1'b0;
            ev1_q        <= 1'b0;
            quad_q       <= 9'd0;
        end else begin
            valid_prev_q <= quadrants_valid_in;
            ev1_q        <= frame_edge;
            if (frame_edge) begin
                quad_q <= quadrants_in;
            end
        end
    end

    // Stage 2: per-frame derived terms
    logic       ev2_q, air_q, gnd_q, empty_q, cand_ok_q;
    logic [1:0] cand_col_q;
    logic       top, bottom, cand_ok;
    logic [1:0] cand_col;

    always_comb begin
        top      = |quad_q[2:0];
        bottom   = |quad_q[8:6];
        cand_ok  = 1'b1;
        cand_col = 2'd1;
        // Only a single lit cell in the middle row names a lane
        case (quad_q[5:3])
            3'b001:  cand_col = 2'd0;
            3'b010:  cand_col = 2'd1;
            3'b100:  cand_col = 2'd2;
            default: cand_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge pixel_clock_in) begin
        if (rst_in) begin
            ev2_q      <= 1'b0;
            air_q      <= 1'b0;
            gnd_q      <= 1'b0;
            empty_q    <= 1'b0;
            cand_ok_q  <= 1'b0;
            cand_col_q <= 2'd1;
        end else begin
            ev2_q      <= ev1_q;
            air_q      <= top & ~bottom;
            gnd_q      <= bottom;
            empty_q    <= (quad_q == 9'd0);
            cand_ok_q  <= cand_ok;
            cand_col_q <= cand_col;
        end
    end

    // Stage 3: lane debounce and presence
    logic [1:0] cand_q, cand_d, lane_q, lane_d;
    logic [3:0] stable_q, stable_d, lost_q, lost_d;
    logic       present_q, present_d, out_valid_q;

    always_comb begin
        cand_d    = cand_q;
        stable_d  = stable_q;
        lane_d    = lane_q;
        lost_d    = lost_q;
        present_d = present_q;
        if (ev2_q) begin
            if (cand_ok_q) begin
                if (cand_col_q == cand_q) begin
                    stable_d = (stable_q == 4'hF) ? stable_q : stable_q + 4'd1;
                end else begin
                    cand_d   = cand_col_q;
                    stable_d = 4'd1;
                end
                if (stable_d >= LANE_N) begin
                    lane_d = cand_col_q;
                end
            end else begin
                stable_d = 4'd0;
            end
            if (empty_q) begin
                lost_d = (lost_q == 4'hF) ? lost_q : lost_q + 4'd1;
                if (lost_d >= LOST_N) begin
                    present_d = 1'b0;
                end
            end else begin
                lost_d    = 4'd0;
                present_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clock_in) begin
        if (rst_in) begin
            cand_q      <= 2'd1;
            stable_q    <= 4'd0;
            lane_q      <= 2'd1;
            lost_q      <= 4'd0;
            present_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cand_q      <= cand_d;
            stable_q    <= stable_d;
            lane_q      <= lane_d;
            lost_q      <= lost_d;
            present_q   <= present_d;
            out_valid_q <= ev2_q;
        end
    end

    // Stage 3: jump state machine, one transition per frame
    jump_state_e state_q;
    logic [3:0]  jcnt_q, rcnt_q;
    logic        jump_q;

    always_ff @(posedge pixel_clock_in) begin
        if (rst_in) begin
            state_q <= GROUNDED;
            jcnt_q  <= 4'd0;
            rcnt_q  <= 4'd0;
            jump_q  <= 1'b0;
        end else begin
            jump_q <= 1'b0;
            if (ev2_q) begin
                case (state_q)
                    GROUNDED: begin
                        if (air_q) begin
                            if (JUMP_N == 4'd1) begin
                                jump_q  <= 1'b1;
                                jcnt_q  <= 4'd0;
                                state_q <= AIRBORNE;
                            end else begin
                                jcnt_q  <= 4'd1;
                                state_q <= RISING;
                            end
                        end
                    end
                    RISING: begin
                        if (air_q) begin
                            if (jcnt_q + 4'd1 == JUMP_N) begin
                                jump_q  <= 1'b1;
                                jcnt_q  <= 4'd0;
                                state_q <= AIRBORNE;
                            end else begin
                                jcnt_q <= jcnt_q + 4'd1;
                            end
                        end else begin
                            jcnt_q  <= 4'd0;
                            state_q <= GROUNDED;
                        end
                    end
                    AIRBORNE: begin
                        if (gnd_q) begin
                            if (rcnt_q + 4'd1 >= REARM_N) begin
                                rcnt_q  <= 4'd0;
                                state_q <= GROUNDED;
                            end else begin
                                rcnt_q <= rcnt_q + 4'd1;
                            end
                        end else begin
                            rcnt_q <= 4'd0;
                        end
                    end
                    default: begin
                        jcnt_q  <= 4'd0;
                        rcnt_q  <= 4'd0;
                        state_q <= GROUNDED;
                    end
                endcase
            end
        end
    end

    assign lane           = lane_q;
    assign jump           = jump_q;
    assign player_present = present_q;
    assign out_valid      = out_valid_q;

endmodule

// File: tb/tb_player_input_filter.sv
// tb/tb_player_input_filter.sv - table, corner-case and randomized model checks for player_input_filter
module tb_player_input_filter;

    localparam int LANE_N  = 3;
    localparam int JUMP_N  = 2;
    localparam int REARM_N = 2;
    localparam int LOST_N  = 8;

    localparam logic [8:0] Q_G = 9'b010_010_000;  // q4|q7 centre, grounded
    localparam logic [8:0] Q_L = 9'b001_001_000;  // q3|q6 left, grounded
    localparam logic [8:0] Q_R = 9'b100_100_000;  // q5|q8 right, grounded
    localparam logic [8:0] Q_A = 9'b000_010_010;  // q1|q4 centre, airborne
    localparam logic [8:0] Q_E = 9'b000_000_000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] quadrants = 9'd0;
    logic       valid = 1'b0;
    logic [1:0] lane;
    logic       jump;
    logic       player_present;
    logic       out_valid;

    player_input_filter #(
        .LANE_STABLE_FRAMES(LANE_N),
        .JUMP_FRAMES(JUMP_N),
        .REARM_FRAMES(REARM_N),
        .LOST_FRAMES(LOST_N)
    ) dut (
        .pixel_clock_in(clk),
        .rst_in(rst),
        .quadrants_in(quadrants),
        .quadrants_valid_in(valid),
        .lane(lane),
        .jump(jump),
        .player_present(player_present),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [8:0] q;
        int         hold;
        int         lane;
        int         jmp;
        int         pres;
    } vec_t;

    vec_t tbl[$];

    int g_lane, g_jump, g_pres;

    // Apply one frame event and check out_valid timing; capture outputs at the pulse
    task automatic do_frame(input logic [8:0] q, input int hold);
        logic ov1, ov2, ov3, j3;
        int   extra;
        extra = 0;
        @(negedge clk);
        quadrants = q;
        valid     = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 ov1 = out_valid;
        @(posedge clk); #1 ov2 = out_valid;
        g_lane = int'(lane);
        g_jump = int'(jump);
        g_pres = int'(player_present);
        @(posedge clk); #1 ov3 = out_valid;
        j3 = jump;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        @(negedge clk);
        valid     = 1'b0;
        quadrants = 9'($urandom);
        @(negedge clk);
        chk("out_valid_timing", int'({ov1, ov2, ov3}), 3'b010);
        chk("jump_width", int'(j3), 0);
        if (hold > 0) chk("out_valid_on_hold", extra, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model: run lengths of frame properties since reset
    int m_lane, m_pres, m_jump, m_armed;
    int last_c, c_run, e_run, a_run, g_run;

    task automatic model_reset();
        m_lane = 1; m_pres = 0; m_jump = 0; m_armed = 1;
        last_c = -1; c_run = 0; e_run = 0; a_run = 0; g_run = 0;
    endtask

    task automatic model_step(input logic [8:0] q);
        int c;
        bit air, gnd;
        c = -1;
        if (q[5:3] == 3'b001) c = 0;
        else if (q[5:3] == 3'b010) c = 1;
        else if (q[5:3] == 3'b100) c = 2;
        if (c < 0) begin
            c_run = 0;
        end else begin
            c_run = (c == last_c) ? c_run + 1 : 1;
            if (c_run >= LANE_N) m_lane = c;
        end
        last_c = c;
        if (q == 9'd0) begin
            e_run++;
            if (e_run >= LOST_N) m_pres = 0;
        end else begin
            e_run  = 0;
            m_pres = 1;
        end
        air = (q[2:0] != 0) && (q[8:6] == 0);
        gnd = (q[8:6] != 0);
        a_run = air ? a_run + 1 : 0;
        g_run = gnd ? g_run + 1 : 0;
        m_jump = 0;
        if (m_armed != 0) begin
            if (a_run == JUMP_N) begin
                m_jump  = 1;
                m_armed = 0;
            end
        end else if (g_run >= REARM_N) begin
            m_armed = 1;
        end
    endtask

    initial begin
        // centre frames
        for (int i = 0; i < 3; i++) tbl.push_back('{Q_G, 0, 1, 0, 1});
        // L,L,R,L,L,L ; last one held high for 500 cycles
        tbl.push_back('{Q_L, 0, 1, 0, 1});
        tbl.push_back('{Q_L, 0, 1, 0, 1});
        tbl.push_back('{Q_R, 0, 1, 0, 1});
        tbl.push_back('{Q_L, 0, 1, 0, 1});
        tbl.push_back('{Q_L, 0, 1, 0, 1});
        tbl.push_back('{Q_L, 500, 0, 0, 1});
        // grounded, two airborne -> jump (lane also settles back to centre)
        tbl.push_back('{Q_G, 0, 0, 0, 1});
        tbl.push_back('{Q_A, 0, 0, 0, 1});
        tbl.push_back('{Q_A, 0, 1, 1, 1});
        tbl.push_back('{Q_A, 0, 1, 0, 1});
        tbl.push_back('{Q_G, 0, 1, 0, 1});
        tbl.push_back('{Q_G, 0, 1, 0, 1});
        tbl.push_back('{Q_A, 0, 1, 0, 1});
        tbl.push_back('{Q_A, 0, 1, 1, 1});
        // rearm, then alternating airborne/grounded never fires
        tbl.push_back('{Q_G, 0, 1, 0, 1});
        tbl.push_back('{Q_G, 0, 1, 0, 1});
        for (int i = 0; i < 3; i++) begin
            tbl.push_back('{Q_A, 0, 1, 0, 1});
            tbl.push_back('{Q_G, 0, 1, 0, 1});
        end
        // loss of player
        for (int i = 0; i < LOST_N - 1; i++) tbl.push_back('{Q_E, 0, 1, 0, 1});
        tbl.push_back('{Q_E, 0, 1, 0, 0});
        tbl.push_back('{Q_E, 0, 1, 0, 0});
        tbl.push_back('{Q_G, 0, 1, 0, 1});

        do_reset();
        #1;
        chk("reset_lane", int'(lane), 1);
        chk("reset_jump", int'(jump), 0);
        chk("reset_present", int'(player_present), 0);
        chk("reset_out_valid", int'(out_valid), 0);

        foreach (tbl[i]) begin
            do_frame(tbl[i].q, tbl[i].hold);
            chk($sformatf("tbl%0d_lane", i), g_lane, tbl[i].lane);
            chk($sformatf("tbl%0d_jump", i), g_jump, tbl[i].jmp);
            chk($sformatf("tbl%0d_present", i), g_pres, tbl[i].pres);
        end

        // Reset one cycle after the edge of an airborne frame while RISING
        begin
            int ov_seen, j_seen;
            do_reset();
            do_frame(Q_G, 0);
            do_frame(Q_A, 0);
            @(negedge clk);
            quadrants = Q_A;
            valid     = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rst   = 1'b1;
            valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            ov_seen = 0;
            j_seen  = 0;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                if (out_valid) ov_seen++;
                if (jump) j_seen++;
            end
            chk("rst_mid_out_valid", ov_seen, 0);
            chk("rst_mid_jump", j_seen, 0);
            chk("rst_mid_lane", int'(lane), 1);
            chk("rst_mid_present", int'(player_present), 0);
            do_frame(Q_A, 0);
            chk("rst_mid_air1_jump", g_jump, 0);
            do_frame(Q_A, 0);
            chk("rst_mid_air2_jump", g_jump, 1);
        end

        // Randomized frames against the reference model
        do_reset();
        model_reset();
        for (int n = 0; n < 200; n++) begin
            logic [8:0] qv;
            case ($urandom_range(0, 7))
                0: qv = Q_E;
                1: qv = Q_G;
                2: qv = Q_L;
                3: qv = Q_R;
                4: qv = Q_A;
                5: qv = 9'b000_001_001;
                6: qv = 9'b000_100_100;
                default: qv = 9'($urandom);
            endcase
            do_frame(qv, $urandom_range(0, 3));
            model_step(qv);
            chk($sformatf("rnd%0d_lane", n), g_lane, m_lane);
            chk($sformatf("rnd%0d_jump", n), g_jump, m_jump);
            chk($sformatf("rnd%0d_present", n), g_pres, m_pres);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
